mg_seq_divider: RTL and testbench



---
 rtl/mg_div_pkg.sv | 19 +
 rtl/mg_div_step.sv | 26 ++
 rtl/mg_seq_divider.sv | 161 ++++++++++++++++
 tb/tb_mg_seq_divider.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mg_div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
// Holds the FSM encoding, the counter-width helper and the divide-by-zero quotient.
package mg_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Divide-by-zero quotient, sliced down to the operand width by the user.
  localparam logic [31:0] DBZ_QUOT = 32'hFFFF_FFFF;

  // Iteration counter width; it must hold WIDTH-1.
  function automatic int cnt_w(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/mg_div_step.sv
// One restoring-division iteration: shift {rem,q} left, WIDTH+1-bit trial subtract, select.
// Purely combinational.
module mg_div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic [WIDTH-1:0] q_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_out,
  output logic [WIDTH-1:0] q_out
);

  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] trial;
  logic           take;

  always_comb begin
    rem_sh  = {rem_in[WIDTH-1:0], q_in[WIDTH-1]};
    trial   = rem_sh - {1'b0, divisor};
    // A set bit shifted out of the top already exceeds any WIDTH-bit divisor.
    take    = rem_in[WIDTH] | ~trial[WIDTH];
    rem_out = take ? trial : rem_sh;
    q_out   = {q_in[WIDTH-2:0], take};
  end

endmodule

// File: rtl/mg_seq_divider.sv
// Iterative radix-2 restoring divider, valid/ready in and out; WIDTH cycles (1 for divide-by-zero).
// Results hold while out_ready is low; define MG_DIV_SIGNED_EN for two's complement (one extra cycle).
module mg_seq_divider
  import mg_div_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = cnt_w(WIDTH);

  state_t           state;
  state_t           state_nxt;
  logic             accept;
  logic             calc_end;

  logic [WIDTH:0]   rem_r;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] dvs_r;
  logic [CNT_W-1:0] cnt_r;
  logic             dbz_r;

  logic [WIDTH:0]   rem_step;
  logic [WIDTH-1:0] q_step;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;

`ifdef MG_DIV_SIGNED_EN
  logic             fix_r;
  logic             neg_q_r;
  logic             neg_r_r;

  // Magnitude of MIN is MIN itself, which is the correct unsigned value.
  assign dvd_mag  = dividend[WIDTH-1] ? (WIDTH'(0) - dividend) : dividend;
  assign dvs_mag  = divisor[WIDTH-1]  ? (WIDTH'(0) - divisor)  : divisor;
  assign calc_end = fix_r;
`else
  assign dvd_mag  = dividend;
  assign dvs_mag  = divisor;
  assign calc_end = (cnt_r == '0);
`endif

  mg_div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_r),
    .q_in    (q_r),
    .divisor (dvs_r),
    .rem_out (rem_step),
    .q_out   (q_step)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = (divisor == '0) ? DONE : CALC;
        end
      end
      CALC: begin
        if (calc_end) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem_r   <= '0;
      q_r     <= '0;
      dvs_r   <= '0;
      cnt_r   <= '0;
      dbz_r   <= 1'b0;
`ifdef MG_DIV_SIGNED_EN
      fix_r   <= 1'b0;
      neg_q_r <= 1'b0;
      neg_r_r <= 1'b0;
`endif
    end else if (accept) begin
      dvs_r <= dvs_mag;
      cnt_r <= CNT_W'(WIDTH - 1);
      if (divisor == '0) begin
        q_r   <= DBZ_QUOT[WIDTH-1:0];
        rem_r <= {1'b0, dividend};
        dbz_r <= 1'b1;
      end else begin
        q_r   <= dvd_mag;
        rem_r <= '0;
        dbz_r <= 1'b0;
      end
`ifdef MG_DIV_SIGNED_EN
      fix_r   <= 1'b0;
      neg_q_r <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
      neg_r_r <= dividend[WIDTH-1];
`endif
    end else if (state == CALC) begin
`ifdef MG_DIV_SIGNED_EN
      if (fix_r) begin
        // Sign fix-up cycle: quotient truncates toward zero, remainder follows the dividend.
        if (neg_q_r) begin
          q_r <= WIDTH'(0) - q_r;
        end
        if (neg_r_r) begin
          rem_r <= {1'b0, WIDTH'(0) - rem_r[WIDTH-1:0]};
        end
        fix_r <= 1'b0;
      end else begin
        q_r   <= q_step;
        rem_r <= rem_step;
        if (cnt_r == '0) begin
          fix_r <= 1'b1;
        end else begin
          cnt_r <= cnt_r - CNT_W'(1);
        end
      end
`else
      q_r   <= q_step;
      rem_r <= rem_step;
      if (cnt_r != '0) begin
        cnt_r <= cnt_r - CNT_W'(1);
      end
`endif
    end
  end

  assign quotient    = q_r;
  assign remainder   = rem_r[WIDTH-1:0];
  assign div_by_zero = dbz_r;

endmodule

// File: tb/tb_mg_seq_divider.sv
// Self-checking bench for mg_seq_divider: vector table, random operands, backpressure and mid-CALC reset.
// Build with MG_DIV_SIGNED_EN defined to exercise the signed variant.
module tb_mg_seq_divider;

  localparam int W = 8;
  // Edges counted from and including the accepting edge until out_valid is seen.
`ifdef MG_DIV_SIGNED_EN
  localparam int LAT = W + 2;
`else
  localparam int LAT = W + 1;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
    int           lat;
  } vec_t;

  localparam int NVEC = 9;
  vec_t tbl [NVEC];
  vec_t sb_q [$];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mg_seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [W-1:0] a, input logic [W-1:0] b);
    vec_t v;
    int   sa;
    int   sd;
    v.a = a;
    v.b = b;
    if (b == '0) begin
      v.q   = '1;
      v.r   = a;
      v.z   = 1'b1;
      v.lat = 1;
    end else begin
`ifdef MG_DIV_SIGNED_EN
      sa  = $signed(a);
      sd  = $signed(b);
      v.q = W'(sa / sd);
      v.r = W'(sa % sd);
`else
      sa  = int'(a);
      sd  = int'(b);
      v.q = W'(sa / sd);
      v.r = W'(sa % sd);
`endif
      v.z   = 1'b0;
      v.lat = LAT;
    end
    return v;
  endfunction

  // Issue one operation, optionally stall the consumer, then retire it.
  task automatic run_op(input vec_t v, input int hold);
    int   lat;
    vec_t e;
    @(negedge clk);
    check("in_ready_idle", in_ready, 1);
    dividend = v.a;
    divisor  = v.b;
    in_valid = 1'b1;
    sb_q.push_back(v);
    @(posedge clk);
    #1;
    lat = 1;
    // Keep in_valid high with junk operands: nothing may be taken outside IDLE.
    dividend = W'($urandom);
    divisor  = W'($urandom);
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    in_valid = 1'b0;
    if (!out_valid) begin
      check("out_valid_timeout", 0, 1);
      return;
    end
    check("latency", lat, v.lat);
    if (sb_q.size() == 0) begin
      check("scoreboard_empty", 0, 1);
      return;
    end
    e = sb_q.pop_front();
    for (int i = 0; i <= hold; i++) begin
      check("quotient", quotient, e.q);
      check("remainder", remainder, e.r);
      check("div_by_zero", div_by_zero, e.z);
      check("out_valid_done", out_valid, 1);
      check("in_ready_done", in_ready, 0);
      if (i < hold) begin
        @(posedge clk);
        #1;
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    check("in_ready_before_ack", in_ready, 0);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("out_valid_after_ack", out_valid, 0);
    check("in_ready_after_ack", in_ready, 1);
  endtask

  initial begin
    vec_t v;

`ifdef MG_DIV_SIGNED_EN
    tbl[0] = '{8'hF9, 8'h02, 8'hFD, 8'hFF, 1'b0, LAT};  // -7/2
    tbl[1] = '{8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, LAT};  // MIN/-1
    tbl[2] = '{8'h07, 8'hFE, 8'hFD, 8'h01, 1'b0, LAT};  // 7/-2
    tbl[3] = '{8'hF9, 8'hFE, 8'h03, 8'hFF, 1'b0, LAT};  // -7/-2
    tbl[4] = '{8'hFB, 8'h00, 8'hFF, 8'hFB, 1'b1, 1};    // -5/0
    tbl[5] = '{8'd100, 8'd9, 8'd11, 8'd1, 1'b0, LAT};
    tbl[6] = '{8'h7F, 8'h80, 8'h00, 8'h7F, 1'b0, LAT};  // 127/-128
    tbl[7] = '{8'h80, 8'h07, 8'hEE, 8'hFE, 1'b0, LAT};  // -128/7
    tbl[8] = '{8'h00, 8'h00, 8'hFF, 8'h00, 1'b1, 1};
`else
    tbl[0] = '{8'd200, 8'd7, 8'd28, 8'd4, 1'b0, LAT};
    tbl[1] = '{8'd3, 8'd10, 8'd0, 8'd3, 1'b0, LAT};
    tbl[2] = '{8'd255, 8'd1, 8'd255, 8'd0, 1'b0, LAT};
    tbl[3] = '{8'd255, 8'd255, 8'd1, 8'd0, 1'b0, LAT};
    tbl[4] = '{8'd5, 8'd0, 8'd255, 8'd5, 1'b1, 1};
    tbl[5] = '{8'd0, 8'd5, 8'd0, 8'd0, 1'b0, LAT};
    tbl[6] = '{8'd128, 8'd3, 8'd42, 8'd2, 1'b0, LAT};
    tbl[7] = '{8'd1, 8'd255, 8'd0, 8'd1, 1'b0, LAT};
    tbl[8] = '{8'd0, 8'd0, 8'd255, 8'd0, 1'b1, 1};
`endif

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_quotient", quotient, 0);
    check("rst_remainder", remainder, 0);
    check("rst_div_by_zero", div_by_zero, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      run_op(tbl[i], 0);
    end

    // Backpressure: 100/9 held for five stalled cycles.
    v = '{8'd100, 8'd9, 8'd11, 8'd1, 1'b0, LAT};
    run_op(v, 5);

    // Reset during the fourth iteration of 200/7 must abort without output.
    @(negedge clk);
    dividend = 8'd200;
    divisor  = 8'd7;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_in_ready", in_ready, 1);
    check("abort_quotient", quotient, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("abort_no_output", out_valid, 0);
    v = '{8'd50, 8'd6, 8'd8, 8'd2, 1'b0, LAT};
    run_op(v, 0);

    for (int i = 0; i < 20; i++) begin
      v = mk(W'($urandom), (i % 7 == 3) ? W'(0) : W'($urandom));
      run_op(v, i % 3);
    end

    check("scoreboard_drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
